universal_shift_reg: RTL and testbench
======================================

// Module: universal_shift_reg
// PURPOSE
//  Parametrised universal shift register. Successor to the single-bit D storage element.
//  Generalised to WIDTH bits, with four modes: hold, shift right, shift left, parallel load.
//  Adds an optional rotate mode and a shift counter that flags when a full word has been serialised.
//  Used as the serialiser/deserialiser and general data register in the datapath library.
// PARAMETERS
//  WIDTH   4  register width in bits (>=2)
//  ROTATE  0  1: shifts rotate (serial inputs ignored); 0: shifts take serial inputs
// PORTS
//  Clk          in   1                   rising-edge clock
//  reset_b      in   1                   asynchronous, active-low reset
//  enable       in   1                   1: mode acts on the edge; 0: register, count and done all hold
//  clear        in   1                   synchronous clear; overrides enable and mode
//  mode         in   2                   00 hold, 01 shift right, 10 shift left, 11 parallel load
//  ser_in_msb   in   1                   bit entering the MSB on a right shift
//  ser_in_lsb   in   1                   bit entering the LSB on a left shift
//  par_in       in   WIDTH               parallel load data
//  par_out      out  WIDTH               register contents
//  msb_out      out  1                   par_out[WIDTH-1], combinational
//  lsb_out      out  1                   par_out[0], combinational
//  shift_count  out  CW=$clog2(WIDTH+1)  shifts since the last load or clear, saturating
//  count_done   out  1                   registered; 1 when shift_count==WIDTH
// BEHAVIOUR
//  - Reset (reset_b=0): immediate and asynchronous.
//    par_out=0, shift_count=0, count_done=0. Holds while low; the first edge after release acts normally.
//  - Priority on each rising Clk edge: clear > !enable > mode.
//  - clear=1: par_out=0, shift_count=0, count_done=0, regardless of enable and mode.
//  - enable=0, clear=0: all state holds, including count and done.
//  - mode 00: hold; count unchanged.
//  - mode 01, ROTATE=0: par_out <= {ser_in_msb, par_out[WIDTH-1:1]}.
//  - mode 01, ROTATE=1: par_out <= {par_out[0], par_out[WIDTH-1:1]}.
//  - mode 10, ROTATE=0: par_out <= {par_out[WIDTH-2:0], ser_in_lsb}.
//  - mode 10, ROTATE=1: par_out <= {par_out[WIDTH-2:0], par_out[WIDTH-1]}.
//  - mode 11: par_out <= par_in; shift_count <= 0; count_done <= 0.
//  - Counting: each right or left shift increments shift_count, saturating at WIDTH (no wrap).
//    Right and left shifts count the same.
//  - count_done is set on the same edge that shift_count reaches WIDTH.
//    It stays 1 through further shifts; only load, clear or reset drop it.
//  - Latency: one edge for every mode; no combinational path from inputs to par_out.
//  - Simultaneous events: a load with clear=1 gives clear. A mode change takes effect on the next edge.
// STRUCTURE
//  - Shared header usr_defs.vh holds the mode encodings:
//    USR_HOLD=2'b00, USR_SHR=2'b01, USR_SHL=2'b10, USR_LOAD=2'b11.
//  - One sub-module, usr_stage: 4:1 mux (hold/right-neighbour/left-neighbour/par_in bit) plus D flip-flop.
//    It has asynchronous active-low reset and clear/enable gating.
//  - Top level generates WIDTH usr_stage instances.
//    Edge stages get their neighbours from the serial inputs or, when ROTATE=1, from the opposite end.
//  - Top level also holds the saturating counter and the count_done flop.
// TESTING (WIDTH=4 unless noted)
//  1. Mid-operation reset: par_out=1011, count=2, then reset_b=0 between edges
//     -> par_out=0000, count=0, done=0 at once, and held until release.
//  2. Load then shift right: mode=11, par_in=1011, one edge -> 1011, count=0.
//     Then mode=01, ser_in_msb=1, four edges -> 1101,1110,1111,1111; count 1..4; done=1 on the 4th edge.
//     A 5th shift -> count stays 4, done stays 1.
//  3. Shift left: load 1011, then mode=10, ser_in_lsb=0, one edge -> 0110, lsb_out=0, msb_out=0, count=1.
//  4. Gating: par_out=1011, enable=0, mode=11, par_in=1111 -> no change after 3 edges.
//     Then clear=1 with enable=0 -> 0000, count=0, done=0.
//  5. Rotate (ROTATE=1): load 1011; mode=01 -> 1101; then mode=10 -> 1011; then mode=10 -> 0111.
//     Serial inputs are held at 0 throughout and have no effect.
//  6. Load after done: after done=1, mode=11 with par_in=0101 -> par_out=0101, count=0, done=0 on that edge.

Source files
------------

// File: rtl/universal_shift_reg_pkg.sv
// Mode encodings and small helpers shared by the universal shift register and its bit stage.
package universal_shift_reg_pkg;

    localparam logic [1:0] USR_HOLD = 2'b00;
    localparam logic [1:0] USR_SHR  = 2'b01;
    localparam logic [1:0] USR_SHL  = 2'b10;
    localparam logic [1:0] USR_LOAD = 2'b11;

    function automatic logic is_shift(input logic [1:0] mode);
        return (mode == USR_SHR) || (mode == USR_SHL);
    endfunction

endpackage

// File: rtl/universal_shift_reg_stage.sv
// One bit of the universal shift register: 4:1 mode mux feeding a flop with clear/enable gating.
module universal_shift_reg_stage
    import universal_shift_reg_pkg::*;
(
    input  logic       Clk,
    input  logic       reset_b,
    input  logic       enable,
    input  logic       clear,
    input  logic [1:0] mode,
    input  logic       from_higher,
    input  logic       from_lower,
    input  logic       par_bit,
    output logic       q
);

    logic q_reg;

    always_ff @(posedge Clk or negedge reset_b) begin
        if (!reset_b) begin
            q_reg <= 1'b0;
        end else if (clear) begin
            q_reg <= 1'b0;
        end else if (enable) begin
            case (mode)
                USR_SHR:  q_reg <= from_higher;
                USR_SHL:  q_reg <= from_lower;
                USR_LOAD: q_reg <= par_bit;
                default:  q_reg <= q_reg;
            endcase
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: hold / shift right / shift left / parallel load,
// optional rotate, and a saturating shift counter with a word-serialised flag.
module universal_shift_reg
    import universal_shift_reg_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter int ROTATE = 0,
    localparam int CW    = $clog2(WIDTH + 1)
) (
    input  logic             Clk,
    input  logic             reset_b,
    input  logic             enable,
    input  logic             clear,
    input  logic [1:0]       mode,
    input  logic             ser_in_msb,
    input  logic             ser_in_lsb,
    input  logic [WIDTH-1:0] par_in,
    output logic [WIDTH-1:0] par_out,
    output logic             msb_out,
    output logic             lsb_out,
    output logic [CW-1:0]    shift_count,
    output logic             count_done
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(WIDTH);

    logic [WIDTH-1:0] q_bits;
    logic [WIDTH-1:0] hi_nb;
    logic [WIDTH-1:0] lo_nb;
    logic [CW-1:0]    shift_count_reg;
    logic             count_done_reg;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_stage
            // End stages take the serial input, or wrap to the opposite end when rotating.
            if (gi == WIDTH - 1) begin : g_msb
                assign hi_nb[gi] = (ROTATE != 0) ? q_bits[0] : ser_in_msb;
            end else begin : g_mid_hi
                assign hi_nb[gi] = q_bits[gi+1];
            end
            if (gi == 0) begin : g_lsb
                assign lo_nb[gi] = (ROTATE != 0) ? q_bits[WIDTH-1] : ser_in_lsb;
            end else begin : g_mid_lo
                assign lo_nb[gi] = q_bits[gi-1];
            end

            universal_shift_reg_stage u_stage (
                .Clk         (Clk),
                .reset_b     (reset_b),
                .enable      (enable),
                .clear       (clear),
                .mode        (mode),
                .from_higher (hi_nb[gi]),
                .from_lower  (lo_nb[gi]),
                .par_bit     (par_in[gi]),
                .q           (q_bits[gi])
            );
        end
    endgenerate

    always_ff @(posedge Clk or negedge reset_b) begin
        if (!reset_b) begin
            shift_count_reg <= '0;
            count_done_reg  <= 1'b0;
        end else if (clear) begin
            shift_count_reg <= '0;
            count_done_reg  <= 1'b0;
        end else if (enable) begin
            if (mode == USR_LOAD) begin
                shift_count_reg <= '0;
                count_done_reg  <= 1'b0;
            end else if (is_shift(mode) && (shift_count_reg != FULL_COUNT)) begin
                // Done rises on the same edge the count reaches full, then sticks.
                shift_count_reg <= shift_count_reg + 1'b1;
                if (shift_count_reg == FULL_COUNT - 1'b1) begin
                    count_done_reg <= 1'b1;
                end
            end
        end
    end

    assign par_out     = q_bits;
    assign msb_out     = q_bits[WIDTH-1];
    assign lsb_out     = q_bits[0];
    assign shift_count = shift_count_reg;
    assign count_done  = count_done_reg;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Drives a plain and a rotating 4-bit universal shift register side by side and compares both
// against an arithmetic reference model, with directed scenarios followed by random traffic.
module tb_universal_shift_reg;

    localparam int W  = 4;
    localparam int CW = $clog2(W + 1);

    logic         clk = 1'b0;
    logic         reset_b;
    logic         enable;
    logic         clear;
    logic [1:0]   mode;
    logic         ser_in_msb;
    logic         ser_in_lsb;
    logic [W-1:0] par_in;

    logic [W-1:0]  po0, po1;
    logic          msb0, msb1, lsb0, lsb1;
    logic [CW-1:0] sc0, sc1;
    logic          dn0, dn1;

    int errors = 0;
    int checks = 0;
    int mv[2];
    int mc[2];

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(W), .ROTATE(0)) dut_std (
        .Clk(clk), .reset_b(reset_b), .enable(enable), .clear(clear), .mode(mode),
        .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb), .par_in(par_in),
        .par_out(po0), .msb_out(msb0), .lsb_out(lsb0), .shift_count(sc0), .count_done(dn0)
    );

    universal_shift_reg #(.WIDTH(W), .ROTATE(1)) dut_rot (
        .Clk(clk), .reset_b(reset_b), .enable(enable), .clear(clear), .mode(mode),
        .ser_in_msb(ser_in_msb), .ser_in_lsb(ser_in_lsb), .par_in(par_in),
        .par_out(po1), .msb_out(msb1), .lsb_out(lsb1), .shift_count(sc1), .count_done(dn1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " std par_out"}, 32'(po0), 32'(mv[0]));
        chk({tag, " std msb_out"}, 32'(msb0), 32'((mv[0] >> (W - 1)) & 1));
        chk({tag, " std lsb_out"}, 32'(lsb0), 32'(mv[0] & 1));
        chk({tag, " std count"},   32'(sc0), 32'(mc[0]));
        chk({tag, " std done"},    32'(dn0), 32'(mc[0] == W));
        chk({tag, " rot par_out"}, 32'(po1), 32'(mv[1]));
        chk({tag, " rot msb_out"}, 32'(msb1), 32'((mv[1] >> (W - 1)) & 1));
        chk({tag, " rot lsb_out"}, 32'(lsb1), 32'(mv[1] & 1));
        chk({tag, " rot count"},   32'(sc1), 32'(mc[1]));
        chk({tag, " rot done"},    32'(dn1), 32'(mc[1] == W));
        $display("%s: mode=%0d en=%0b clr=%0b std=%b/%0d/%0b rot=%b/%0d/%0b",
                 tag, mode, enable, clear, po0, sc0, dn0, po1, sc1, dn1);
    endtask

    // Reference behaviour: register as an integer word, shifts as arithmetic on it.
    task automatic model_edge();
        int mask;
        int in_bit;
        mask = (1 << W) - 1;
        for (int r = 0; r < 2; r++) begin
            if (!reset_b || clear) begin
                mv[r] = 0;
                mc[r] = 0;
            end else if (enable) begin
                if (mode == 2'd1) begin
                    in_bit = (r == 1) ? (mv[r] & 1) : int'(ser_in_msb);
                    mv[r]  = (mv[r] >> 1) | (in_bit << (W - 1));
                    if (mc[r] < W) mc[r]++;
                end else if (mode == 2'd2) begin
                    in_bit = (r == 1) ? ((mv[r] >> (W - 1)) & 1) : int'(ser_in_lsb);
                    mv[r]  = ((mv[r] << 1) & mask) | in_bit;
                    if (mc[r] < W) mc[r]++;
                end else if (mode == 2'd3) begin
                    mv[r] = int'(par_in);
                    mc[r] = 0;
                end
            end
        end
    endtask

    task automatic drive(input logic en, input logic clr, input logic [1:0] md,
                         input logic smsb, input logic slsb, input logic [W-1:0] pin);
        enable = en; clear = clr; mode = md;
        ser_in_msb = smsb; ser_in_lsb = slsb; par_in = pin;
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin
        mv[0] = 0; mv[1] = 0; mc[0] = 0; mc[1] = 0;
        reset_b = 1'b0;
        drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0, '0);
        #2;
        check_all("reset");
        @(negedge clk);
        reset_b = 1'b1;

        // Mid-operation asynchronous reset from 1011 with two shifts counted.
        drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 4'b1110);
        step("t1 load");
        drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b1, 4'b0000);
        step("t1 shl1");
        step("t1 shl2");
        chk("t1 pre-reset value", 32'(po0), 32'hB);
        chk("t1 pre-reset count", 32'(sc0), 32'd2);
        #2;
        reset_b = 1'b0;
        mv[0] = 0; mv[1] = 0; mc[0] = 0; mc[1] = 0;
        #1;
        check_all("t1 async reset");
        step("t1 reset held a");
        step("t1 reset held b");
        @(negedge clk);
        reset_b = 1'b1;

        // Load then shift right with ser_in_msb=1, past saturation.
        drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 4'b1011);
        step("t2 load");
        drive(1'b1, 1'b0, 2'b01, 1'b1, 1'b0, 4'b0000);
        step("t2 shr1");
        chk("t2 shr1 const", 32'(po0), 32'hD);
        step("t2 shr2");
        step("t2 shr3");
        step("t2 shr4");
        chk("t2 shr4 const", 32'(po0), 32'hF);
        chk("t2 done const", 32'(dn0), 32'd1);
        step("t2 shr5 saturate");
        chk("t2 count sat const", 32'(sc0), 32'd4);

        // Load after done drops count and done on the load edge.
        drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 4'b0101);
        step("t6 load after done");
        chk("t6 done const", 32'(dn0), 32'd0);

        // Shift left from 1011 with ser_in_lsb=0.
        drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 4'b1011);
        step("t3 load");
        drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 4'b0000);
        step("t3 shl");
        chk("t3 shl const", 32'(po0), 32'h6);

        // Gating: disabled load has no effect, clear overrides disable.
        drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 4'b1011);
        step("t4 load");
        drive(1'b0, 1'b0, 2'b11, 1'b1, 1'b1, 4'b1111);
        step("t4 gated a");
        step("t4 gated b");
        step("t4 gated c");
        chk("t4 gated const", 32'(po0), 32'hB);
        drive(1'b0, 1'b1, 2'b11, 1'b1, 1'b1, 4'b1111);
        step("t4 clear");

        // Rotate sequence with serial inputs held low.
        drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0, 4'b1011);
        step("t5 load");
        drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 4'b0000);
        step("t5 ror");
        chk("t5 ror const", 32'(po1), 32'hD);
        drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b0, 4'b0000);
        step("t5 rol1");
        chk("t5 rol1 const", 32'(po1), 32'hB);
        step("t5 rol2");
        chk("t5 rol2 const", 32'(po1), 32'h7);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 7) != 0), ($urandom_range(0, 19) == 0),
                  2'($urandom_range(0, 3)), 1'($urandom), 1'($urandom),
                  W'($urandom));
            step($sformatf("rand %0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
